// File: rtl/shift_seq_pkg.sv
// shift_seq_pkg
// Shared definitions for the shift sequencer slice: the two-bit operation
// encoding carried on in_op and the sequencer state type.
// No ports (package).
// Optional feature macro used by the top: SHIFT_SEQ_STATS_EN.

package shift_seq_pkg;

  localparam logic [1:0] OP_SHR = 2'b00;
  localparam logic [1:0] OP_SHL = 2'b01;
  localparam logic [1:0] OP_ROR = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_step.sv
// shift_step
// Combinational single-bit shift/rotate of a WIDTH-bit word.
// Ports:
//   op  in  [1:0]        operation (OP_SHR, OP_SHL, OP_ROR, OP_ROL)
//   d   in  [WIDTH-1:0]  operand
//   q   out [WIDTH-1:0]  operand moved by exactly one bit position

module shift_step
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_comb begin
    q = d;
    case (op)
      OP_SHR:  q = {1'b0, d[WIDTH-1:1]};
      OP_SHL:  q = {d[WIDTH-2:0], 1'b0};
      OP_ROR:  q = {d[0], d[WIDTH-1:1]};
      OP_ROL:  q = {d[WIDTH-2:0], d[WIDTH-1]};
      default: q = d;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer
// Multi-cycle barrel-shift replacement: accepts a command (op, amount, data),
// applies one single-bit step per cycle, then holds the result until the
// consumer takes it.
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   in_valid   in   command present
//   in_ready   out  command can be accepted (IDLE only)
//   in_op      in   [1:0] 00 shr, 01 shl, 10 ror, 11 rol
//   in_amt     in   [AMT_W-1:0] number of single-bit steps
//   in_data    in   [WIDTH-1:0] operand
//   out_valid  out  result present (DONE only)
//   out_ready  in   consumer accepts result
//   out_data   out  [WIDTH-1:0] result (working register)
//   busy       out  any state other than IDLE
//   cmd_count  out  [15:0] saturating result-handshake count, only when
//                   SHIFT_SEQ_STATS_EN is defined

module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [AMT_W-1:0] in_amt,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
`ifdef SHIFT_SEQ_STATS_EN
  ,
  output logic [15:0]      cmd_count
`endif
);

  localparam logic [AMT_W-1:0] CNT_ONE = AMT_W'(1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] work, work_nxt;
  logic [AMT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       op_q, op_nxt;
  logic [WIDTH-1:0] step_out;
  logic             rdy_en;
  logic             accept;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .op (op_q),
    .d  (work),
    .q  (step_out)
  );

  // rdy_en keeps in_ready low while rst is high and releases it on the
  // first clock edge after reset, even though the FSM already sits in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdy_en <= 1'b0;
    else     rdy_en <= 1'b1;
  end

  assign in_ready  = (state == IDLE) && rdy_en;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_data  = work;
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      work  <= '0;
      cnt   <= '0;
      op_q  <= OP_SHR;
    end else begin
      state <= state_nxt;
      work  <= work_nxt;
      cnt   <= cnt_nxt;
      op_q  <= op_nxt;
    end
  end

  // A zero amount skips SHIFT entirely; otherwise SHIFT runs exactly
  // in_amt cycles and leaves on the step that takes the counter from 1 to 0.
  always_comb begin
    state_nxt = state;
    work_nxt  = work;
    cnt_nxt   = cnt;
    op_nxt    = op_q;
    case (state)
      IDLE: begin
        if (accept) begin
          op_nxt    = in_op;
          work_nxt  = in_data;
          cnt_nxt   = in_amt;
          state_nxt = (in_amt != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        work_nxt = step_out;
        cnt_nxt  = cnt - CNT_ONE;
        if (cnt == CNT_ONE) state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef SHIFT_SEQ_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cmd_count <= 16'd0;
    else if (out_valid && out_ready && (cmd_count != 16'hFFFF))
      cmd_count <= cmd_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer
// Self-checking bench for shift_sequencer: directed vector table, a
// backpressure sequence, randomized commands against a reference model,
// and a reset-abort sequence. Checks cmd_count when SHIFT_SEQ_STATS_EN is set.

module tb_shift_sequencer;

  localparam int WIDTH = 8;
  localparam int AMT_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [AMT_W-1:0] in_amt;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             busy;
`ifdef SHIFT_SEQ_STATS_EN
  logic [15:0]      cmd_count;
`endif

  int checks = 0;
  int errors = 0;
  int handshakes = 0;

  typedef struct {
    logic [1:0] op;
    logic [2:0] amt;
    logic [7:0] data;
    logic [7:0] exp;
    int         lat;
  } vec_t;

  vec_t vecs[7];

  shift_sequencer #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_amt    (in_amt),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
`ifdef SHIFT_SEQ_STATS_EN
    ,
    .cmd_count (cmd_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference: shifts by plain arithmetic, rotates via a doubled word.
  function automatic logic [7:0] refModel(input logic [1:0] op, input int amt,
                                          input logic [7:0] data);
    logic [15:0] dbl;
    dbl = {data, data};
    case (op)
      2'b00:   return data >> amt;
      2'b01:   begin dbl = {8'h00, data} << amt; return dbl[7:0]; end
      2'b10:   begin dbl = dbl >> amt; return dbl[7:0]; end
      default: begin dbl = dbl << amt; return dbl[15:8]; end
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Issues one command, scrambles inputs while the block is busy, holds
  // out_ready low for 'hold' cycles once the result is up, then drains.
  task automatic applyStimulus(input logic [1:0] op, input logic [2:0] amt,
                               input logic [7:0] data, input logic [7:0] exp,
                               input int hold, output logic [7:0] res,
                               output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("accept_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_op    = op;
    in_amt   = amt;
    in_data  = data;
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      in_valid = 1'($urandom);
      in_op    = 2'($urandom);
      in_amt   = 3'($urandom);
      in_data  = 8'($urandom);
    end while (!out_valid && lat < 20);
    res = out_data;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkOutput("hold_data", 32'(out_data), 32'(exp));
      checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
      checkOutput("hold_valid", 32'(out_valid), 32'd1);
      in_valid = 1'b1;
      in_op    = 2'($urandom);
      in_amt   = 3'($urandom);
      in_data  = 8'($urandom);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    handshakes++;
    checkOutput("drain_valid", 32'(out_valid), 32'd0);
    checkOutput("drain_in_ready", 32'(in_ready), 32'd1);
    checkOutput("drain_busy", 32'(busy), 32'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] res;
    int         lat;
    logic [1:0] rop;
    logic [2:0] ramt;
    logic [7:0] rdata;

    vecs[0] = '{2'd0, 3'd3, 8'hB5, 8'h16, 4};
    vecs[1] = '{2'd1, 3'd2, 8'hB5, 8'hD4, 3};
    vecs[2] = '{2'd2, 3'd1, 8'hB5, 8'hDA, 2};
    vecs[3] = '{2'd3, 3'd4, 8'hB5, 8'h5B, 5};
    vecs[4] = '{2'd0, 3'd0, 8'h3C, 8'h3C, 1};
    vecs[5] = '{2'd3, 3'd7, 8'h81, 8'hC0, 8};
    vecs[6] = '{2'd2, 3'd7, 8'h01, 8'h02, 8};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_op     = 2'd0;
    in_amt    = 3'd0;
    in_data   = 8'd0;
    out_ready = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_out_data", 32'(out_data), 32'd0);
`ifdef SHIFT_SEQ_STATS_EN
    checkOutput("rst_cmd_count", 32'(cmd_count), 32'd0);
`endif
    rst = 1'b0;
    #1;
    checkOutput("post_rst_before_edge", 32'(in_ready), 32'd0);
    @(negedge clk);
    checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].op, vecs[i].amt, vecs[i].data, vecs[i].exp, 0, res, lat);
      checkOutput($sformatf("vec%0d_data", i), 32'(res), 32'(vecs[i].exp));
      checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
    end

    $display("[TB] backpressure sequence");
    applyStimulus(2'd0, 3'd3, 8'hB5, 8'h16, 5, res, lat);
    checkOutput("bp_data", 32'(res), 32'h16);
    checkOutput("bp_latency", 32'(lat), 32'd4);

    $display("[TB] random commands");
    for (int i = 0; i < 40; i++) begin
      rop   = 2'($urandom);
      ramt  = 3'($urandom);
      rdata = 8'($urandom);
      applyStimulus(rop, ramt, rdata, refModel(rop, int'(ramt), rdata),
                    int'($urandom_range(0, 3)), res, lat);
      checkOutput($sformatf("rand%0d_data op=%0d amt=%0d d=%0h", i, rop, ramt, rdata),
                  32'(res), 32'(refModel(rop, int'(ramt), rdata)));
      checkOutput($sformatf("rand%0d_latency", i), 32'(lat), 32'(ramt) + 32'd1);
    end

`ifdef SHIFT_SEQ_STATS_EN
    checkOutput("cmd_count_total", 32'(cmd_count), 32'(handshakes));
`endif

    $display("[TB] reset abort sequence");
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = 2'd3;
    in_amt   = 3'd7;
    in_data  = 8'hA7;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
    checkOutput("abort_out_data", 32'(out_data), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_in_ready", 32'(in_ready), 32'd0);
`ifdef SHIFT_SEQ_STATS_EN
    checkOutput("abort_cmd_count", 32'(cmd_count), 32'd0);
`endif
    repeat (2) @(negedge clk);
    checkOutput("abort_hold_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    handshakes = 0;
    @(negedge clk);
    checkOutput("abort_release_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("abort_no_result", 32'(out_valid), 32'd0);
    end
`ifdef SHIFT_SEQ_STATS_EN
    checkOutput("abort_cmd_count_after", 32'(cmd_count), 32'd0);
`endif

    applyStimulus(2'd1, 3'd2, 8'hB5, 8'hD4, 1, res, lat);
    checkOutput("after_abort_data", 32'(res), 32'hD4);
    checkOutput("after_abort_latency", 32'(lat), 32'd3);
`ifdef SHIFT_SEQ_STATS_EN
    checkOutput("after_abort_cmd_count", 32'(cmd_count), 32'(handshakes));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
